// File: rtl/spi_master_param.sv
// spi_master_param: parametrised full-duplex SPI master, all four SPI modes selectable per transfer.
// Optional macro SPI_LSB_FIRST_EN adds a lsb_first input that selects LSB-first wire order per transfer.
module spi_master_param #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_SS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        ss_sel,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic              miso,
    output logic              mosi,
    output logic              sclk,
    output logic [NUM_SS-1:0] ss_n,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [DIV_W-1:0]  div_cnt_reg;
    logic [EDGE_W-1:0] edge_cnt_reg;
    logic [DATA_W-1:0] tx_sh_reg;
    logic [DATA_W-1:0] rx_sh_reg;
    logic              cpol_reg;
    logic              cpha_reg;
    logic              sclk_reg;
    logic              mosi_reg;
    logic [NUM_SS-1:0] ss_n_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic              busy_reg;
    logic              done_reg;

    logic              div_tick;
    logic              last_edge;
    logic              leading_edge;
    logic              sample_now;
    logic              shift_now;
    logic              accept;
    logic              lsb_req;
    logic              lsb_mode;
    logic              first_bit;
    logic              next_bit;
    logic [DATA_W-1:0] tx_shifted;
    logic [DATA_W-1:0] rx_shifted;
    logic [NUM_SS-1:0] ss_dec;

`ifdef SPI_LSB_FIRST_EN
    logic lsb_first_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsb_first_reg <= 1'b0;
        end else if (accept) begin
            lsb_first_reg <= lsb_first;
        end
    end

    assign lsb_req  = lsb_first;
    assign lsb_mode = lsb_first_reg;
`else
    assign lsb_req  = 1'b0;
    assign lsb_mode = 1'b0;
`endif

    // An out-of-range ss_sel matches no line, so every select stays high.
    generate
        for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_ss_dec
            assign ss_dec[gi] = (ss_sel != 2'(gi));
        end
    endgenerate

    assign accept       = (state_reg == ST_IDLE) && start;
    assign div_tick     = (div_cnt_reg == DIV_LAST);
    assign last_edge    = (edge_cnt_reg == EDGE_LAST);
    assign leading_edge = ~edge_cnt_reg[0];

    assign first_bit  = lsb_req ? data_in[0] : data_in[DATA_W-1];
    assign next_bit   = lsb_mode ? tx_sh_reg[1] : tx_sh_reg[DATA_W-2];
    assign tx_shifted = lsb_mode ? (tx_sh_reg >> 1) : (tx_sh_reg << 1);
    assign rx_shifted = lsb_mode ? {miso, rx_sh_reg[DATA_W-1:1]}
                                 : {rx_sh_reg[DATA_W-2:0], miso};

    // CPHA=1 skips the first leading shift because the first bit was already driven in SETUP.
    always_comb begin
        sample_now = 1'b0;
        shift_now  = 1'b0;
        if ((state_reg == ST_XFER) && div_tick) begin
            sample_now = leading_edge ^ cpha_reg;
            if (cpha_reg) begin
                shift_now = leading_edge && (edge_cnt_reg != '0);
            end else begin
                shift_now = !leading_edge && !last_edge;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_SETUP;
            ST_SETUP: if (div_tick) state_next = ST_XFER;
            ST_XFER:  if (div_tick && last_edge) state_next = ST_HOLD;
            ST_HOLD:  if (div_tick) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            tx_sh_reg    <= '0;
            rx_sh_reg    <= '0;
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
            ss_n_reg     <= '1;
            data_out_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    sclk_reg    <= cpol;
                    div_cnt_reg <= '0;
                    if (start) begin
                        tx_sh_reg    <= data_in;
                        rx_sh_reg    <= '0;
                        cpol_reg     <= cpol;
                        cpha_reg     <= cpha;
                        mosi_reg     <= first_bit;
                        ss_n_reg     <= ss_dec;
                        edge_cnt_reg <= '0;
                        busy_reg     <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    div_cnt_reg <= div_tick ? '0 : div_cnt_reg + DIV_W'(1);
                end
                ST_XFER: begin
                    div_cnt_reg <= div_tick ? '0 : div_cnt_reg + DIV_W'(1);
                    if (div_tick) begin
                        sclk_reg     <= ~sclk_reg;
                        edge_cnt_reg <= last_edge ? '0 : edge_cnt_reg + EDGE_W'(1);
                    end
                    if (sample_now) begin
                        rx_sh_reg <= rx_shifted;
                    end
                    if (shift_now) begin
                        tx_sh_reg <= tx_shifted;
                        mosi_reg  <= next_bit;
                    end
                end
                ST_HOLD: begin
                    div_cnt_reg <= div_tick ? '0 : div_cnt_reg + DIV_W'(1);
                    sclk_reg    <= cpol_reg;
                    // Release the select on entry to DONE so it is high for the whole DONE cycle.
                    if (div_tick) begin
                        ss_n_reg <= '1;
                    end
                end
                ST_DONE: begin
                    div_cnt_reg  <= '0;
                    data_out_reg <= rx_sh_reg;
                    done_reg     <= 1'b1;
                    busy_reg     <= 1'b0;
                end
                default: begin
                    div_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign mosi     = mosi_reg;
    assign sclk     = sclk_reg;
    assign ss_n     = ss_n_reg;
    assign data_out = data_out_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: default instance (8-bit, div 4, 4 selects) and a 16-bit, div 1, 2-select instance.
module tb_spi_master_param;

    localparam int A_W   = 8;
    localparam int A_DIV = 4;
    localparam int A_LAT = 1 + A_DIV + 2 * A_W * A_DIV + A_DIV;
    localparam int B_W   = 16;
    localparam int B_DIV = 1;
    localparam int B_LAT = 1 + B_DIV + 2 * B_W * B_DIV + B_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // instance A signals
    logic           a_start = 1'b0;
    logic [A_W-1:0] a_data_in = '0;
    logic [1:0]     a_ss_sel = '0;
    logic           a_cpol = 1'b0;
    logic           a_cpha = 1'b0;
    logic           a_miso = 1'b0;
    logic           a_mosi, a_sclk, a_busy, a_done;
    logic [3:0]     a_ss_n;
    logic [A_W-1:0] a_data_out;

    // instance B signals
    logic           b_start = 1'b0;
    logic [B_W-1:0] b_data_in = '0;
    logic [1:0]     b_ss_sel = '0;
    logic           b_cpol = 1'b0;
    logic           b_cpha = 1'b0;
    logic           b_miso = 1'b0;
    logic           b_mosi, b_sclk, b_busy, b_done;
    logic [1:0]     b_ss_n;
    logic [B_W-1:0] b_data_out;

    spi_master_param #(.DATA_W(A_W), .CLK_DIV(A_DIV), .NUM_SS(4)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .data_in(a_data_in), .ss_sel(a_ss_sel),
        .cpol(a_cpol), .cpha(a_cpha), .miso(a_miso), .mosi(a_mosi), .sclk(a_sclk),
        .ss_n(a_ss_n), .data_out(a_data_out), .busy(a_busy), .done(a_done)
    );

    spi_master_param #(.DATA_W(B_W), .CLK_DIV(B_DIV), .NUM_SS(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .data_in(b_data_in), .ss_sel(b_ss_sel),
        .cpol(b_cpol), .cpha(b_cpha), .miso(b_miso), .mosi(b_mosi), .sclk(b_sclk),
        .ss_n(b_ss_n), .data_out(b_data_out), .busy(b_busy), .done(b_done)
    );

    // Slave models: react to SCLK edges relative to the transfer's idle level.
    // CPHA=0 presents bit 0 up front, the next bit after each trailing edge, samples on leading edges.
    // CPHA=1 presents bit n-1 at leading edge n and samples on trailing edges.
    logic           a_mode_cpol = 1'b0, a_mode_cpha = 1'b0, a_arm = 1'b0, a_arm_seen = 1'b0;
    logic [A_W-1:0] a_sword = '0, a_got = '0;
    int             a_lead = 0, a_trail = 0, a_nsamp = 0, a_idx = 0;

    always @(a_sclk or a_arm) begin
        if (a_arm !== a_arm_seen) begin
            a_arm_seen = a_arm;
            a_lead = 0; a_trail = 0; a_nsamp = 0; a_got = '0;
            a_miso = a_mode_cpha ? 1'b0 : a_sword[A_W-1];
        end else if (a_sclk !== a_mode_cpol) begin
            a_lead++;
            if (a_mode_cpha) begin
                if (a_lead <= A_W) begin a_idx = A_W - a_lead; a_miso = a_sword[a_idx]; end
            end else if (a_nsamp < A_W) begin
                a_got = {a_got[A_W-2:0], a_mosi}; a_nsamp++;
            end
        end else begin
            a_trail++;
            if (a_mode_cpha) begin
                if (a_nsamp < A_W) begin a_got = {a_got[A_W-2:0], a_mosi}; a_nsamp++; end
            end else if (a_trail < A_W) begin
                a_idx = A_W - 1 - a_trail; a_miso = a_sword[a_idx];
            end
        end
    end

    logic           b_mode_cpol = 1'b0, b_mode_cpha = 1'b0, b_arm = 1'b0, b_arm_seen = 1'b0;
    logic [B_W-1:0] b_sword = '0, b_got = '0;
    int             b_lead = 0, b_trail = 0, b_nsamp = 0, b_idx = 0;

    always @(b_sclk or b_arm) begin
        if (b_arm !== b_arm_seen) begin
            b_arm_seen = b_arm;
            b_lead = 0; b_trail = 0; b_nsamp = 0; b_got = '0;
            b_miso = b_mode_cpha ? 1'b0 : b_sword[B_W-1];
        end else if (b_sclk !== b_mode_cpol) begin
            b_lead++;
            if (b_mode_cpha) begin
                if (b_lead <= B_W) begin b_idx = B_W - b_lead; b_miso = b_sword[b_idx]; end
            end else if (b_nsamp < B_W) begin
                b_got = {b_got[B_W-2:0], b_mosi}; b_nsamp++;
            end
        end else begin
            b_trail++;
            if (b_mode_cpha) begin
                if (b_nsamp < B_W) begin b_got = {b_got[B_W-2:0], b_mosi}; b_nsamp++; end
            end else if (b_trail < B_W) begin
                b_idx = B_W - 1 - b_trail; b_miso = b_sword[b_idx];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 plain, 1 start re-asserted mid-transfer, 2 reset at cycle 30, 3 start held through done
    task automatic run_a(input logic [A_W-1:0] din, input logic [A_W-1:0] sword, input logic [1:0] sel,
                         input logic pol, input logic pha, input int mode, input string tag);
        int lat;
        logic [3:0] exp_ss;
        lat = -1;
        exp_ss = 4'hF;
        exp_ss[sel] = 1'b0;
        @(negedge clk);
        a_cpol = pol; a_cpha = pha; a_ss_sel = sel; a_data_in = din;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_idle_sclk"}, 32'(a_sclk), 32'(pol));
        a_mode_cpol = pol; a_mode_cpha = pha; a_sword = sword; a_arm = ~a_arm;
        a_start = 1'b1;
        @(posedge clk);
        #1;
        if (mode != 3) a_start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) chk({tag, "_busy"}, 32'(a_busy), 32'd1);
            if (k == 10) chk({tag, "_ss_n"}, 32'(a_ss_n), 32'(exp_ss));
            if (mode == 1 && k == 20) begin
                a_start = 1'b1; a_data_in = 8'h55; a_cpol = ~pol; a_cpha = ~pha; a_ss_sel = sel + 2'd1;
            end
            if (mode == 1 && k == 21) begin
                a_start = 1'b0; a_data_in = din; a_cpol = pol; a_cpha = pha; a_ss_sel = sel;
            end
            if (mode == 2 && k == 30) begin
                rst = 1'b1;
                #1;
                chk({tag, "_abort_ss_n"}, 32'(a_ss_n), 32'hF);
                chk({tag, "_abort_sclk"}, 32'(a_sclk), 32'd0);
                chk({tag, "_abort_busy"}, 32'(a_busy), 32'd0);
                chk({tag, "_abort_dout"}, 32'(a_data_out), 32'd0);
                @(posedge clk);
                #1;
                chk({tag, "_abort_done"}, 32'(a_done), 32'd0);
                chk({tag, "_abort_ss_n2"}, 32'(a_ss_n), 32'hF);
                @(negedge clk);
                rst = 1'b0;
                lat = 0;
                break;
            end
            if (a_done === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) return;
        chk({tag, "_latency"}, 32'(lat), 32'(A_LAT));
        chk({tag, "_data_out"}, 32'(a_data_out), 32'(sword));
        chk({tag, "_slave_rx"}, 32'(a_got), 32'(din));
        chk({tag, "_end_sclk"}, 32'(a_sclk), 32'(pol));
        chk({tag, "_end_ss_n"}, 32'(a_ss_n), 32'hF);
        chk({tag, "_end_busy"}, 32'(a_busy), 32'd0);
        if (mode == 3) begin
            @(posedge clk);
            #1;
            chk({tag, "_re_busy"}, 32'(a_busy), 32'd1);
            chk({tag, "_re_ss_n"}, 32'(a_ss_n), 32'(exp_ss));
            a_start = 1'b0;
            lat = -1;
            for (int k = 1; k <= 200; k++) begin
                @(posedge clk);
                #1;
                if (a_done === 1'b1) begin
                    lat = k;
                    break;
                end
            end
            chk({tag, "_re_latency"}, 32'(lat), 32'(A_LAT));
        end else begin
            @(posedge clk);
            #1;
            chk({tag, "_single_done"}, 32'(a_done), 32'd0);
            chk({tag, "_idle_busy"}, 32'(a_busy), 32'd0);
        end
    endtask

    task automatic run_b(input logic [B_W-1:0] din, input logic [B_W-1:0] sword, input logic [1:0] sel,
                         input logic pol, input logic pha, input string tag);
        int lat;
        logic [1:0] exp_ss;
        lat = -1;
        exp_ss = 2'b11;
        if (sel < 2'd2) exp_ss[sel[0]] = 1'b0;
        @(negedge clk);
        b_cpol = pol; b_cpha = pha; b_ss_sel = sel; b_data_in = din;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_idle_sclk"}, 32'(b_sclk), 32'(pol));
        b_mode_cpol = pol; b_mode_cpha = pha; b_sword = sword; b_arm = ~b_arm;
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) chk({tag, "_ss_n"}, 32'(b_ss_n), 32'(exp_ss));
            if (b_done === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(B_LAT));
        chk({tag, "_data_out"}, 32'(b_data_out), 32'(sword));
        chk({tag, "_slave_rx"}, 32'(b_got), 32'(din));
        chk({tag, "_end_sclk"}, 32'(b_sclk), 32'(pol));
        @(posedge clk);
        #1;
        chk({tag, "_single_done"}, 32'(b_done), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(a_sclk), 32'd0);
        chk("rst_mosi", 32'(a_mosi), 32'd0);
        chk("rst_ss_n", 32'(a_ss_n), 32'hF);
        chk("rst_dout", 32'(a_data_out), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_b_ss_n", 32'(b_ss_n), 32'h3);
        rst = 1'b0;

        run_a(8'hAD, 8'hCA, 2'd0, 1'b0, 1'b0, 0, "mode0");
        run_a(8'hAD, 8'hCA, 2'd0, 1'b1, 1'b1, 0, "mode3");
        run_a(8'h3C, 8'h96, 2'd2, 1'b0, 1'b1, 0, "ss2");
        run_a(8'hAD, 8'hCA, 2'd1, 1'b1, 1'b0, 1, "busy_start");
        run_a(8'hE7, 8'h18, 2'd3, 1'b0, 1'b0, 2, "abort");
        run_a(8'h81, 8'h7E, 2'd3, 1'b0, 1'b0, 0, "post_abort");
        run_a(8'h5A, 8'hA5, 2'd1, 1'b0, 1'b1, 3, "held_start");
        for (int i = 0; i < 8; i++) begin
            run_a(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 0,
                  $sformatf("rand_a%0d", i));
        end

        run_b(16'hBEEF, 16'h1234, 2'd0, 1'b0, 1'b0, "b16");
        run_b(16'hC0DE, 16'hFACE, 2'd3, 1'b1, 1'b1, "b_ss_oob");
        for (int i = 0; i < 6; i++) begin
            run_b(16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                  $sformatf("rand_b%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
